// File: rtl/mmio_confreg.sv
// Splits CPU data accesses between data RAM and an MMIO config-register window, with 1-cycle read latency.
// Optional free-running timer at offset E000 is built only when MMIO_TIMER_EN is defined.
module mmio_confreg #(
   parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
   parameter logic [31:0] CONF_MASK = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic [3:0]  cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic [15:0] led,
   output logic [1:0]  led_rg0,
   output logic [1:0]  led_rg1,
   output logic [31:0] num_data,
   input  logic [7:0]  switch,
   input  logic [3:0]  btn
);

   localparam logic [15:0] OFF_LED     = 16'hF000;
   localparam logic [15:0] OFF_LED_RG0 = 16'hF004;
   localparam logic [15:0] OFF_LED_RG1 = 16'hF008;
   localparam logic [15:0] OFF_NUM     = 16'hF010;
   localparam logic [15:0] OFF_SWITCH  = 16'hF020;
   localparam logic [15:0] OFF_BTN     = 16'hF024;
   localparam logic [15:0] OFF_TIMER   = 16'hE000;
   localparam logic [15:0] OFF_SCRATCH = 16'hFFF0;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] m;
      m = old_val;
      for (int unsigned i = 0; i < 4; i++)
         if (be[i]) m[8*i +: 8] = new_val[8*i +: 8];
      return m;
   endfunction

   logic        hit;
   logic        wr;
   logic [15:0] off;
   logic [31:0] rd_val;

   logic [15:0] led_q;
   logic [1:0]  led_rg0_q, led_rg1_q;
   logic [31:0] num_q, scratch_q;
   logic [7:0]  sw_meta, sw_sync;
   logic [3:0]  btn_meta, btn_sync;
   logic [31:0] conf_rdata_q;
   logic        sel_conf_q;
`ifdef MMIO_TIMER_EN
   logic [31:0] timer_q;
`endif

   assign off = cpu_addr[15:0];
   assign hit = cpu_en & ((cpu_addr & CONF_MASK) == CONF_BASE);
   assign wr  = hit & (|cpu_we);

   // RAM side sees every non-window access unchanged, including during reset.
   assign ram_en    = cpu_en & ~hit;
   assign ram_we    = hit ? '0 : cpu_we;
   assign ram_addr  = cpu_addr;
   assign ram_wdata = cpu_wdata;

   always_comb begin
      rd_val = '0;
      case (off)
         OFF_LED:     rd_val = {16'h0, led_q};
         OFF_LED_RG0: rd_val = {30'h0, led_rg0_q};
         OFF_LED_RG1: rd_val = {30'h0, led_rg1_q};
         OFF_NUM:     rd_val = num_q;
         OFF_SWITCH:  rd_val = {24'h0, sw_sync};
         OFF_BTN:     rd_val = {28'h0, btn_sync};
`ifdef MMIO_TIMER_EN
         OFF_TIMER:   rd_val = timer_q;
`endif
         OFF_SCRATCH: rd_val = scratch_q;
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q        <= '0;
         led_rg0_q    <= '0;
         led_rg1_q    <= '0;
         num_q        <= '0;
         scratch_q    <= '0;
         sw_meta      <= '0;
         sw_sync      <= '0;
         btn_meta     <= '0;
         btn_sync     <= '0;
         conf_rdata_q <= '0;
         sel_conf_q   <= 1'b0;
      end else begin
         sw_meta  <= switch;
         sw_sync  <= sw_meta;
         btn_meta <= btn;
         btn_sync <= btn_meta;

         // Select is only refreshed by a real request so idle cycles keep the last response.
         if (cpu_en) sel_conf_q <= hit;
         if (hit && cpu_we == '0) conf_rdata_q <= rd_val;

         if (wr) begin
            case (off)
               OFF_LED: begin
                  if (cpu_we[0]) led_q[7:0]  <= cpu_wdata[7:0];
                  if (cpu_we[1]) led_q[15:8] <= cpu_wdata[15:8];
               end
               OFF_LED_RG0: if (cpu_we[0]) led_rg0_q <= cpu_wdata[1:0];
               OFF_LED_RG1: if (cpu_we[0]) led_rg1_q <= cpu_wdata[1:0];
               OFF_NUM:     num_q     <= byte_merge(num_q, cpu_wdata, cpu_we);
               OFF_SCRATCH: scratch_q <= byte_merge(scratch_q, cpu_wdata, cpu_we);
               default: ;
            endcase
         end
      end
   end

`ifdef MMIO_TIMER_EN
   always_ff @(posedge clk) begin
      if (reset)
         timer_q <= '0;
      else if (wr && off == OFF_TIMER)
         timer_q <= byte_merge(timer_q, cpu_wdata, cpu_we);
      else
         timer_q <= timer_q + 32'd1;
   end
`endif

   assign cpu_rdata = sel_conf_q ? conf_rdata_q : ram_rdata;
   assign led       = led_q;
   assign led_rg0   = led_rg0_q;
   assign led_rg1   = led_rg1_q;
   assign num_data  = num_q;

endmodule
